// File: rtl/tok_enc_pkg.sv
// Shared types for the vocabulary token encoder: FSM state encoding and the
// symbol value that terminates words, entries and the input/vocab lists.
package tok_enc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WSTART,
    CMP,
    VSKIP,
    VCHK,
    EMIT,
    ISKIP,
    FIN
  } tok_enc_state_e;

  localparam int SYM_TERM = 0;

endpackage

// File: rtl/tok_skip_scan.sv
// Terminator seek over a 1-cycle-latency memory: walks one address per cycle
// from a loaded start address and flags the first address holding SYM_TERM.
module tok_skip_scan
  import tok_enc_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] start_addr,
  input  logic          run,
  input  logic [DW-1:0] rdata,
  output logic [AW-1:0] addr,
  output logic [AW-1:0] term_addr,
  output logic          found,
  output logic          at_top
);

  localparam logic [DW-1:0] TERM = DW'(SYM_TERM);

  logic [AW-1:0] prev;
  logic          prev_valid;

  // prev is the address whose data is on rdata this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (load) begin
      addr       <= start_addr;
      prev_valid <= 1'b0;
    end else if (run) begin
      prev       <= addr;
      prev_valid <= 1'b1;
      addr       <= addr + AW'(1);
    end
  end

  assign term_addr = prev;
  assign found     = prev_valid && (rdata == TERM);
  assign at_top    = prev_valid && (prev == '1);

endmodule

// File: rtl/vocab_token_encoder.sv
// Word-to-token encoder: looks up each input word in the vocab list and emits
// its entry index (or UNK_ID). Option: VOCAB_TOKEN_ENCODER_UNK_COUNT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// WSTART | read first symbol of a word; empty word ends the input
// CMP    | compare word and current entry symbol by symbol
// VSKIP  | seek the terminator of the rejected entry
// VCHK   | check the next entry exists and the id space is not exhausted
// EMIT   | hold the token until tok_ready
// ISKIP  | seek the terminator of the current word
// FIN    | done pulse, back to IDLE
module vocab_token_encoder
  import tok_enc_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int IN_ADDR_WIDTH  = 6,
  parameter int VOC_ADDR_WIDTH = 8,
  parameter int TOK_WIDTH      = 6,
  parameter int UNK_ID         = 2**TOK_WIDTH - 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [IN_ADDR_WIDTH-1:0]  in_addr,
  input  logic [DATA_WIDTH-1:0]     in_rdata,
  output logic [VOC_ADDR_WIDTH-1:0] voc_addr,
  input  logic [DATA_WIDTH-1:0]     voc_rdata,
  output logic                      tok_valid,
  output logic [TOK_WIDTH-1:0]      tok_id,
  input  logic                      tok_ready
`ifdef VOCAB_TOKEN_ENCODER_UNK_COUNT_EN
  ,
  output logic [IN_ADDR_WIDTH-1:0]  unk_count
`endif
);

  localparam logic [DATA_WIDTH-1:0] TERM = DATA_WIDTH'(SYM_TERM);
  localparam logic [TOK_WIDTH-1:0]  UNK  = TOK_WIDTH'(UNK_ID);

  tok_enc_state_e            state;
  logic [IN_ADDR_WIDTH-1:0]  ws;
  logic [IN_ADDR_WIDTH-1:0]  k;
  logic [VOC_ADDR_WIDTH-1:0] ve;
  logic [TOK_WIDTH-1:0]      idx;
  logic                      rd_phase;
  logic                      end_pending;
  logic                      ve_wrap;

  logic [IN_ADDR_WIDTH-1:0]  ws_k;
  logic [VOC_ADDR_WIDTH-1:0] ve_k;
  logic                      in_load, voc_load;
  logic [IN_ADDR_WIDTH-1:0]  in_scan_addr, in_term;
  logic [VOC_ADDR_WIDTH-1:0] voc_scan_addr, voc_term;
  logic                      in_found, in_top, voc_found, voc_top;

  assign ws_k     = ws + k;
  assign ve_k     = ve + VOC_ADDR_WIDTH'(k);
  assign in_addr  = (state == ISKIP) ? in_scan_addr : ws_k;
  assign voc_addr = (state == VSKIP) ? voc_scan_addr : ve_k;
  assign in_load  = (state == EMIT) && tok_ready;
  assign voc_load = (state == CMP) && rd_phase && (in_rdata != voc_rdata);

  tok_skip_scan #(.AW(IN_ADDR_WIDTH), .DW(DATA_WIDTH)) u_in_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (in_load),
    .start_addr (ws_k),
    .run        (state == ISKIP),
    .rdata      (in_rdata),
    .addr       (in_scan_addr),
    .term_addr  (in_term),
    .found      (in_found),
    .at_top     (in_top)
  );

  tok_skip_scan #(.AW(VOC_ADDR_WIDTH), .DW(DATA_WIDTH)) u_voc_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (voc_load),
    .start_addr (ve_k),
    .run        (state == VSKIP),
    .rdata      (voc_rdata),
    .addr       (voc_scan_addr),
    .term_addr  (voc_term),
    .found      (voc_found),
    .at_top     (voc_top)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ws          <= '0;
      k           <= '0;
      ve          <= '0;
      idx         <= '0;
      rd_phase    <= 1'b0;
      end_pending <= 1'b0;
      ve_wrap     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tok_valid   <= 1'b0;
      tok_id      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ws          <= '0;
          k           <= '0;
          ve          <= '0;
          idx         <= '0;
          ve_wrap     <= 1'b0;
          rd_phase    <= 1'b0;
          end_pending <= 1'b0;
          busy        <= 1'b1;
          state       <= WSTART;
        end
        WSTART: begin
          if (!rd_phase) rd_phase <= 1'b1;
          else if (in_rdata == TERM) begin
            rd_phase <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end else state <= CMP;
        end
        // addresses are already stable on entry, so CMP starts on a data cycle
        CMP: begin
          if (!rd_phase) rd_phase <= 1'b1;
          else if (in_rdata == voc_rdata) begin
            if (in_rdata == TERM) begin
              tok_valid <= 1'b1;
              tok_id    <= idx;
              state     <= EMIT;
            end else begin
              k        <= k + IN_ADDR_WIDTH'(1);
              rd_phase <= 1'b0;
              if (ws_k == '1) end_pending <= 1'b1;
            end
          end else state <= VSKIP;
        end
        VSKIP: if (voc_found) begin
          ve       <= voc_term + VOC_ADDR_WIDTH'(1);
          ve_wrap  <= voc_top;
          idx      <= idx + TOK_WIDTH'(1);
          k        <= '0;
          rd_phase <= 1'b0;
          state    <= VCHK;
        end
        VCHK: begin
          if (!rd_phase) rd_phase <= 1'b1;
          else if (voc_rdata == TERM || idx == '1 || ve_wrap) begin
            tok_valid <= 1'b1;
            tok_id    <= UNK;
            state     <= EMIT;
          end else state <= CMP;
        end
        EMIT: if (tok_ready) begin
          tok_valid <= 1'b0;
          if (end_pending) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else state <= ISKIP;
        end
        // a terminator at the top address, or a scan past it, wraps the input
        ISKIP: begin
          if (in_top) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else if (in_found) begin
            ws       <= in_term + IN_ADDR_WIDTH'(1);
            k        <= '0;
            ve       <= '0;
            idx      <= '0;
            ve_wrap  <= 1'b0;
            rd_phase <= 1'b0;
            state    <= WSTART;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VOCAB_TOKEN_ENCODER_UNK_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) unk_count <= '0;
    else if (state == IDLE && start) unk_count <= '0;
    else if (state == EMIT && tok_ready && tok_id == UNK && unk_count != '1)
      unk_count <= unk_count + IN_ADDR_WIDTH'(1);
  end
`else
  // UNK statistics not built in this configuration
`endif

endmodule

// File: tb/tb_vocab_token_encoder.sv
// Self-checking bench for vocab_token_encoder: memories modelled as 1-cycle
// SRAMs, expected tokens derived from a string-level lookup of each word.
module tb_vocab_token_encoder;

  localparam int UNK = 63;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done;
  logic [5:0] in_addr;
  logic [7:0] in_rdata;
  logic [7:0] voc_addr;
  logic [7:0] voc_rdata;
  logic       tok_valid;
  logic [5:0] tok_id;
  logic       tok_ready;
`ifdef VOCAB_TOKEN_ENCODER_UNK_COUNT_EN
  logic [5:0] unk_count;
`endif

  vocab_token_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_addr   (in_addr),
    .in_rdata  (in_rdata),
    .voc_addr  (voc_addr),
    .voc_rdata (voc_rdata),
    .tok_valid (tok_valid),
    .tok_id    (tok_id),
    .tok_ready (tok_ready)
`ifdef VOCAB_TOKEN_ENCODER_UNK_COUNT_EN
    ,
    .unk_count (unk_count)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] in_mem  [64];
  logic [7:0] voc_mem [256];
  int  exp_q[$];
  int  exp_unk;
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  ready_mode = 0;
  int  stall_left = 0;
  logic       prev_stall = 1'b0;
  logic [5:0] prev_id = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
    in_rdata  <= in_mem[in_addr];
    voc_rdata <= voc_mem[voc_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: string-level lookup ----------------
  function automatic int lookup(input int ws);
    int vp = 0;
    int j;
    for (int e = 0; e < 63; e++) begin
      if (voc_mem[vp] == 0) return UNK;
      j = 0;
      while (in_mem[ws+j] != 0 && in_mem[ws+j] == voc_mem[vp+j]) j++;
      if (in_mem[ws+j] == 0 && voc_mem[vp+j] == 0) return e;
      while (voc_mem[vp] != 0) vp++;
      vp++;
    end
    return UNK;
  endfunction

  task automatic build_expected();
    int ws = 0;
    int t;
    exp_q.delete();
    exp_unk = 0;
    while (in_mem[ws] != 0) begin
      t = lookup(ws);
      exp_q.push_back(t);
      if (t == UNK) exp_unk++;
      while (in_mem[ws] != 0) ws++;
      ws++;
    end
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 64; i++) in_mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) voc_mem[i] = 8'h00;
  endtask

  // '.' in these strings stands for the 0 terminator
  task automatic load_strs(input string vs, input string is);
    clear_mems();
    for (int i = 0; i < vs.len(); i++) voc_mem[i] = (vs[i] == ".") ? 8'h00 : vs[i];
    for (int i = 0; i < is.len(); i++) in_mem[i] = (is[i] == ".") ? 8'h00 : is[i];
  endtask

  task automatic pin(input string name, input int n, input int a, input int b);
    chk({name, "_count"}, exp_q.size(), n);
    if (n > 0) chk({name, "_tok0"}, exp_q[0], a);
    if (n > 1) chk({name, "_tok1"}, exp_q[1], b);
  endtask

  task automatic gen_random();
    logic [7:0] ents [8][4];
    int lens [8];
    int nent, nw, p, q, len, e;
    clear_mems();
    nent = $urandom_range(0, 8);
    p = 0;
    for (int i = 0; i < nent; i++) begin
      lens[i] = $urandom_range(1, 4);
      for (int j = 0; j < lens[i]; j++) begin
        ents[i][j] = 8'h61 + 8'($urandom_range(0, 3));
        voc_mem[p] = ents[i][j];
        p++;
      end
      p++;
    end
    nw = $urandom_range(0, 6);
    q = 0;
    for (int w = 0; w < nw; w++) begin
      if (nent > 0 && $urandom_range(0, 2) != 0) begin
        e = $urandom_range(0, nent - 1);
        for (int j = 0; j < lens[e]; j++) begin
          in_mem[q] = ents[e][j];
          q++;
        end
      end else begin
        len = $urandom_range(1, 5);
        for (int j = 0; j < len; j++) begin
          in_mem[q] = 8'h61 + 8'($urandom_range(0, 3));
          q++;
        end
      end
      q++;
    end
  endtask

  // ---------------- downstream ready driver ----------------
  initial begin
    tok_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tok_ready = 1'b1;
        1: tok_ready = ($urandom_range(0, 1) == 1);
        default: begin
          if (tok_valid && stall_left > 0) begin
            tok_ready = 1'b0;
            stall_left--;
          end else tok_ready = 1'b1;
        end
      endcase
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial forever begin
    @(negedge clk);
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", tok_valid, 1);
        chk("hold_id", tok_id, prev_id);
      end
      if (tok_valid && tok_ready) begin
        if (exp_q.size() == 0) chk("unexpected_token", tok_id, -1);
        else chk("token_id", tok_id, exp_q.pop_front());
      end
      if (done) begin
        chk("busy_at_done", busy, 0);
        chk("tokens_left_at_done", exp_q.size(), 0);
      end
      prev_stall = tok_valid && !tok_ready;
      prev_id    = tok_id;
    end
  end

  task automatic run_case(input int rmode, input bit poke, output int lat);
    int t0;
    bit got = 0;
    lat = -1;
    build_expected();
    ready_mode = rmode;
    stall_left = 5;
    @(posedge clk);
    #1 start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 5000 && !got; i++) begin
      if (poke && i == 6) start = 1'b1;
      if (poke && i == 7) start = 1'b0;
      if (done) begin
        got = 1;
        lat = cyc - t0;
      end else @(negedge clk);
    end
    chk("done_seen", got, 1);
    @(negedge clk);
    chk("done_single_pulse", done, 0);
`ifdef VOCAB_TOKEN_ENCODER_UNK_COUNT_EN
    chk("unk_count", unk_count, exp_unk);
`endif
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    start = 1'b0;
    clear_mems();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tok_valid", tok_valid, 0);
    chk("rst_tok_id", tok_id, 0);
    chk("rst_in_addr", in_addr, 0);
    chk("rst_voc_addr", voc_addr, 0);
    rst_n = 1'b1;

    load_strs("ab.cd..", "cd.ab..");
    build_expected();
    pin("model_basic", 2, 1, 0);
    run_case(0, 1'b0, lat);

    load_strs("ab.cd..", "xy..");
    build_expected();
    pin("model_unk", 1, UNK, 0);
    run_case(0, 1'b0, lat);

    load_strs("abc..", "ab.abcd..");
    build_expected();
    pin("model_prefix", 2, UNK, UNK);
    run_case(1, 1'b0, lat);

    load_strs("..", "ab.b..");
    build_expected();
    pin("model_empty_vocab", 2, UNK, UNK);
    run_case(0, 1'b0, lat);

    load_strs("ab.cd..", "cd.ab..");
    run_case(2, 1'b1, lat);
    chk("backpressure_stall_cycles", stall_left, 0);

    load_strs("ab.cd..", "..");
    build_expected();
    pin("model_empty_input", 0, 0, 0);
    run_case(0, 1'b0, lat);
    chk("empty_done_latency", lat, 3);

    // reset while the first word is being compared
    load_strs("ab.cd..", "cd.ab..");
    build_expected();
    ready_mode = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_tok_valid", tok_valid, 0);
    chk("midrst_tok_id", tok_id, 0);
    chk("midrst_in_addr", in_addr, 0);
    chk("midrst_voc_addr", voc_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_case(0, 1'b0, lat);

    for (int it = 0; it < 40; it++) begin
      gen_random();
      run_case(int'($urandom_range(0, 1)), 1'b0, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
